button_conditioner: RTL
=======================

# button_conditioner

Multi-channel front end for the board push-buttons, placed directly upstream of the stopwatch control logic. Each raw, asynchronous, bouncing button input is synchronised, debounced and turned into a clean level plus single-cycle press, release and auto-repeat pulses. The stopwatch consumes these pulses instead of raw button levels. Auto-repeat lets a held `change` button step digits continuously.

## Interface

- `CHANNELS`, 3: number of independent buttons.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a new level (10 ms at 100 MHz); must be ≥1.
- `REPEAT_DELAY`, 50_000_000: cycles of continuous press before the first repeat pulse; must be ≥1.
- `REPEAT_PERIOD`, 20_000_000: cycles between subsequent repeat pulses; must be ≥1.
- `BTN_ACTIVE_LOW`, 1: 1 means a raw 0 is "pressed".

- `clk_i` input 1: system clock.
- `rstn` input 1: reset, asynchronous, active-high.
- `btn_raw_i` input CHANNELS: raw button pins, asynchronous to `clk_i`.
- `repeat_en_i` input CHANNELS: per-channel auto-repeat enable (synchronous).
- `btn_level_o` output CHANNELS: debounced level, 1 = pressed.
- `press_o` output CHANNELS: one-cycle pulse on an accepted press.
- `release_o` output CHANNELS: one-cycle pulse on an accepted release.
- `repeat_o` output CHANNELS: one-cycle auto-repeat pulse.

## Operation

- **Synchroniser.** Per channel, a 2-FF synchroniser. Both flops reset to the inactive raw level (1 when `BTN_ACTIVE_LOW`). The synchronised value is then normalised: `act = sync XOR BTN_ACTIVE_LOW`.
- **Debounce.**
  - Counter `db_cnt` increments every cycle in which `act` ≠ `btn_level_o`.
  - It clears to 0 on any cycle where `act` = `btn_level_o`.
  - When `db_cnt` = `DEBOUNCE_CYCLES`−1 and `act` still differs, `btn_level_o` toggles on the next edge and `db_cnt` clears.
  - Any glitch shorter than `DEBOUNCE_CYCLES` cycles produces no output activity.
- **Per-channel FSM.**
  - RELEASED: `btn_level_o`=0. Goes to PRESSED on accepted press, with `press_o`=1 for that cycle.
  - PRESSED: hold counter `hd_cnt` increments while `repeat_en_i`=1 and clears while 0. When `hd_cnt` reaches `REPEAT_DELAY`−1, go to REPEATING with `repeat_o` pulsed and `hd_cnt` cleared.
  - REPEATING: `hd_cnt` counts. At `REPEAT_PERIOD`−1, pulse `repeat_o` and clear `hd_cnt`. If `repeat_en_i` drops, go to PRESSED with `hd_cnt` cleared.
  - PRESSED or REPEATING: on accepted release, go to RELEASED with `release_o`=1 for that cycle and `hd_cnt` cleared.
- **Counter widths.** `db_cnt` is `$clog2(DEBOUNCE_CYCLES+1)` bits. `hd_cnt` is `$clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1)` bits. Neither counter wraps: each clears at its terminal count.
- **Pulse exclusivity.** `press_o`, `release_o` and `repeat_o` are mutually exclusive per channel per cycle. A release accepted in the same cycle `hd_cnt` hits terminal count wins, and `repeat_o` is suppressed.
- **Channel independence.** Channels are fully independent, and simultaneous events on different channels are all reported in the same cycle.

## Timing

- **Reset values.** While `rstn`=1, all outputs are 0, FSMs are RELEASED and counters are 0. Reset is asynchronous assert with synchronous internal effect on the next edge after deassert.
- **Reset mid-press.** All state is lost. A button still held after reset is reported as a fresh `press_o` after the full latency.
- **Latency.** A raw transition stable before clock edge k gives `btn_level_o` and the press/release pulse changing after edge k+1+`DEBOUNCE_CYCLES`, i.e. `DEBOUNCE_CYCLES`+2 cycles.
- **Pulse alignment.** `press_o` is high in exactly the first cycle `btn_level_o`=1. `release_o` is high in the first cycle `btn_level_o`=0.
- **Repeat timing.** The first `repeat_o` comes `REPEAT_DELAY` cycles after `press_o` (with `repeat_en_i` held 1). Subsequent pulses come every `REPEAT_PERIOD` cycles.
- **All outputs are registered.**

## Structure

- **Package `button_pkg`:** FSM state encoding (RELEASED=2'd0, PRESSED=2'd1, REPEATING=2'd2) and a `max` helper function for counter width.
- **Sub-module `button_channel`:** one instance per channel via a generate loop. It contains the synchroniser, debounce counter, FSM and hold counter. The top only replicates and concatenates.

## Test plan

Bench parameters: `CHANNELS`=3, `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8, `BTN_ACTIVE_LOW`=1.

- **Clean press.** `btn_raw_i[0]` 1→0 and held, `repeat_en_i`=0 → `press_o[0]` single pulse 6 cycles later; `btn_level_o[0]`=1; no `repeat_o`.
- **Bounce rejection.** Toggle `btn_raw_i[1]` 0/1 with 3-cycle runs ten times, then release → no pulses; `btn_level_o[1]` stays 0.
- **Auto-repeat.** Hold ch2 with `repeat_en_i[2]`=1 for 60 cycles after press → `repeat_o[2]` at +20, +28, +36, +44, +52. On release, one `release_o[2]` and no further repeats.
- **Repeat enable drop.** Drop `repeat_en_i[0]` mid-REPEATING → repeats stop. Re-enable → next repeat after a fresh 20 cycles.
- **Simultaneous channels.** Press all three channels on the same edge → `press_o`=3'b111 in one cycle.
- **Reset mid-press.** Assert `rstn` during a held press → all outputs 0 immediately. After deassert with the button still held → `press_o` again after 6 cycles.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_pkg;

    // Per-channel press/repeat state
    typedef enum logic [1:0] {
        ST_RELEASED  = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_REPEATING = 2'd2
    } btn_state_e;

    // Larger of two counts, used to size the shared hold counter
    function automatic int unsigned max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle: raw pins and repeat enables in, conditioned level and pulses out.
interface button_conditioner_if #(
    parameter int unsigned CHANNELS = 3
);
    logic [CHANNELS-1:0] btn_raw_i;
    logic [CHANNELS-1:0] repeat_en_i;
    logic [CHANNELS-1:0] btn_level_o;
    logic [CHANNELS-1:0] press_o;
    logic [CHANNELS-1:0] release_o;
    logic [CHANNELS-1:0] repeat_o;

    modport master (
        output btn_raw_i, repeat_en_i,
        input  btn_level_o, press_o, release_o, repeat_o
    );

    modport slave (
        input  btn_raw_i, repeat_en_i,
        output btn_level_o, press_o, release_o, repeat_o
    );
endinterface

// File: rtl/button_channel.sv
// One button: 2-FF synchroniser, debounce counter, press/repeat FSM with hold counter.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 20_000_000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk_i,
    input  logic rstn,
    input  logic btn_raw_i,
    input  logic repeat_en_i,
    output logic btn_level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_o
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HD_W = $clog2(max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HD_W-1:0] RD_LAST = HD_W'(REPEAT_DELAY - 1);
    localparam logic [HD_W-1:0] RP_LAST = HD_W'(REPEAT_PERIOD - 1);

    logic            sync1_q, sync2_q;
    logic            act_c;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            accept_c;
    logic            accept_press_c, accept_release_c;
    btn_state_e      state_q;
    logic [HD_W-1:0] hd_cnt_q;
    logic            press_q, release_q, repeat_q;

    // Two-flop synchroniser, parked at the idle pin level
    always_ff @(posedge clk_i or posedge rstn) begin
        if (rstn) begin
            sync1_q <= BTN_ACTIVE_LOW;
            sync2_q <= BTN_ACTIVE_LOW;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign act_c = sync2_q ^ BTN_ACTIVE_LOW;

    // Debounce: count consecutive disagreeing cycles, accept on the last one
    always_comb begin
        db_cnt_d = '0;
        level_d  = level_q;
        accept_c = 1'b0;
        if (act_c != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                accept_c = 1'b1;
                level_d  = act_c;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk_i or posedge rstn) begin
        if (rstn) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    assign accept_press_c   = accept_c & act_c;
    assign accept_release_c = accept_c & ~act_c;

    // Press/repeat FSM; an accepted release always beats a repeat in the same cycle
    always_ff @(posedge clk_i or posedge rstn) begin
        if (rstn) begin
            state_q   <= ST_RELEASED;
            hd_cnt_q  <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                ST_RELEASED: begin
                    hd_cnt_q <= '0;
                    if (accept_press_c) begin
                        state_q <= ST_PRESSED;
                        press_q <= 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (accept_release_c) begin
                        state_q   <= ST_RELEASED;
                        release_q <= 1'b1;
                        hd_cnt_q  <= '0;
                    end else if (!repeat_en_i) begin
                        hd_cnt_q <= '0;
                    end else if (hd_cnt_q == RD_LAST) begin
                        state_q  <= ST_REPEATING;
                        repeat_q <= 1'b1;
                        hd_cnt_q <= '0;
                    end else begin
                        hd_cnt_q <= hd_cnt_q + HD_W'(1);
                    end
                end
                ST_REPEATING: begin
                    if (accept_release_c) begin
                        state_q   <= ST_RELEASED;
                        release_q <= 1'b1;
                        hd_cnt_q  <= '0;
                    end else if (!repeat_en_i) begin
                        state_q  <= ST_PRESSED;
                        hd_cnt_q <= '0;
                    end else if (hd_cnt_q == RP_LAST) begin
                        repeat_q <= 1'b1;
                        hd_cnt_q <= '0;
                    end else begin
                        hd_cnt_q <= hd_cnt_q + HD_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_RELEASED;
                    hd_cnt_q <= '0;
                end
            endcase
        end
    end

    assign btn_level_o = level_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign repeat_o    = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: replicates one conditioner per button.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned CHANNELS        = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 20_000_000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rstn,
    button_conditioner_if.slave  bus
);

    logic [CHANNELS-1:0] level_w;
    logic [CHANNELS-1:0] press_w;
    logic [CHANNELS-1:0] release_w;
    logic [CHANNELS-1:0] repeat_w;

    // Independent channel instances
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
        ) u_ch (
            .clk_i       (clk_i),
            .rstn        (rstn),
            .btn_raw_i   (bus.btn_raw_i[c]),
            .repeat_en_i (bus.repeat_en_i[c]),
            .btn_level_o (level_w[c]),
            .press_o     (press_w[c]),
            .release_o   (release_w[c]),
            .repeat_o    (repeat_w[c])
        );
    end

    assign bus.btn_level_o = level_w;
    assign bus.press_o     = press_w;
    assign bus.release_o   = release_w;
    assign bus.repeat_o    = repeat_w;

endmodule
